jt10_adpcm_romarb: RTL and testbench

Two-requester arbiter that shares the single external ADPCM sample ROM port between the ADPCM-A channel sequencer and the ADPCM-B driver. It sits between both decoders' address/read-strobe outputs and the top-level ROM bus. Each requester gets a one-deep request slot and a one-entry last-byte cache, so repeated nibble reads of the same byte never reach the ROM. Round-robin arbitration and a wait timeout bound every requester's worst-case latency.

---
 rtl/jt10_adpcm_romarb.sv | 182 ++++++++++++++++++
 tb/tb_jt10_adpcm_romarb.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jt10_adpcm_romarb.sv
// Shares the single ADPCM sample ROM port between the ADPCM-A sequencer and
// the ADPCM-B driver. Each requester has a one-deep request slot and a
// one-entry last-byte cache; a round-robin grant and a wait timeout bound the
// latency seen by either side.
module jt10_adpcm_romarb #(
    parameter int TIMEOUT = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_req,
    input  logic [23:0] a_addr,
    output logic [7:0]  a_data,
    output logic        a_ok,
    output logic        a_busy,
    input  logic        b_req,
    input  logic [23:0] b_addr,
    output logic [7:0]  b_data,
    output logic        b_ok,
    output logic        b_busy,
    output logic [23:0] rom_addr,
    output logic        rom_cs,
    input  logic [7:0]  rom_data,
    input  logic        rom_ok,
    output logic        tout_err
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_WAIT = 1'b1;
    localparam logic [4:0] TOUT_LIM = TIMEOUT[4:0];

    // Index 0 is requester A, index 1 is requester B.
    logic        state_q, state_d;
    logic        gnt_q, gnt_d;
    logic        last_q, last_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        cs_q, cs_d;
    logic [23:0] raddr_q, raddr_d;
    logic        tout_q, tout_d;
    logic [1:0]  pend_q, pend_d;
    logic [1:0]  cval_q, cval_d;
    logic [1:0]  ok_q, ok_d;
    logic [23:0] paddr_q [2];
    logic [23:0] paddr_d [2];
    logic [23:0] caddr_q [2];
    logic [23:0] caddr_d [2];
    logic [7:0]  cdata_q [2];
    logic [7:0]  cdata_d [2];
    logic [7:0]  data_q  [2];
    logic [7:0]  data_d  [2];

    logic [1:0]  req;
    logic [23:0] req_addr [2];
    logic [1:0]  busy;
    logic        g;

    // Request capture, cache lookup and the IDLE/WAIT grant machine.
    always_comb begin
        req         = {b_req, a_req};
        req_addr[0] = a_addr;
        req_addr[1] = b_addr;
        busy[0]     = pend_q[0] | (state_q == ST_WAIT && gnt_q == 1'b0);
        busy[1]     = pend_q[1] | (state_q == ST_WAIT && gnt_q == 1'b1);

        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        cs_d    = cs_q;
        raddr_d = raddr_q;
        tout_d  = tout_q;
        pend_d  = pend_q;
        cval_d  = cval_q;
        ok_d    = 2'b00;
        g       = 1'b0;
        for (int i = 0; i < 2; i++) begin
            paddr_d[i] = paddr_q[i];
            caddr_d[i] = caddr_q[i];
            cdata_d[i] = cdata_q[i];
            data_d[i]  = data_q[i];
        end

        // A busy requester's new request is dropped; a hit answers next cycle.
        for (int i = 0; i < 2; i++) begin
            if (req[i] && !busy[i]) begin
                if (cval_q[i] && req_addr[i] == caddr_q[i]) begin
                    ok_d[i]   = 1'b1;
                    data_d[i] = cdata_q[i];
                end else begin
                    pend_d[i]  = 1'b1;
                    paddr_d[i] = req_addr[i];
                end
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (pend_q != 2'b00) begin
                    g       = (pend_q == 2'b11) ? ~last_q : pend_q[1];
                    raddr_d = paddr_q[g];
                    cs_d    = 1'b1;
                    cnt_d   = 5'd0;
                    gnt_d   = g;
                    last_d  = g;
                    state_d = ST_WAIT;
                end
            end
            default: begin
                // An ok seen in the first WAIT cycle may be left over from the
                // previous fetch, so it only counts once cnt has moved.
                if (cnt_q != 5'd0 && rom_ok) begin
                    cs_d           = 1'b0;
                    data_d[gnt_q]  = rom_data;
                    ok_d[gnt_q]    = 1'b1;
                    caddr_d[gnt_q] = raddr_q;
                    cdata_d[gnt_q] = rom_data;
                    cval_d[gnt_q]  = 1'b1;
                    pend_d[gnt_q]  = 1'b0;
                    state_d        = ST_IDLE;
                end else if (cnt_q == TOUT_LIM) begin
                    cs_d          = 1'b0;
                    data_d[gnt_q] = 8'h00;
                    ok_d[gnt_q]   = 1'b1;
                    tout_d        = 1'b1;
                    pend_d[gnt_q] = 1'b0;
                    state_d       = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
        endcase
    end

    // State registers; reset clears everything, caches included.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= 5'd0;
            cs_q    <= 1'b0;
            raddr_q <= 24'd0;
            tout_q  <= 1'b0;
            pend_q  <= 2'b00;
            cval_q  <= 2'b00;
            ok_q    <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                paddr_q[i] <= 24'd0;
                caddr_q[i] <= 24'd0;
                cdata_q[i] <= 8'd0;
                data_q[i]  <= 8'd0;
            end
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            cs_q    <= cs_d;
            raddr_q <= raddr_d;
            tout_q  <= tout_d;
            pend_q  <= pend_d;
            cval_q  <= cval_d;
            ok_q    <= ok_d;
            for (int i = 0; i < 2; i++) begin
                paddr_q[i] <= paddr_d[i];
                caddr_q[i] <= caddr_d[i];
                cdata_q[i] <= cdata_d[i];
                data_q[i]  <= data_d[i];
            end
        end
    end

    assign a_data   = data_q[0];
    assign b_data   = data_q[1];
    assign a_ok     = ok_q[0];
    assign b_ok     = ok_q[1];
    assign a_busy   = pend_q[0] | (state_q == ST_WAIT && gnt_q == 1'b0);
    assign b_busy   = pend_q[1] | (state_q == ST_WAIT && gnt_q == 1'b1);
    assign rom_addr = raddr_q;
    assign rom_cs   = cs_q;
    assign tout_err = tout_q;

endmodule

// File: tb/tb_jt10_adpcm_romarb.sv
// Directed bench for the ADPCM ROM arbiter: miss, cache hit, round-robin,
// busy drop, timeout, stale ok and asynchronous reset.
module tb_jt10_adpcm_romarb;

    logic        clk;
    logic        rst;
    logic        a_req, b_req;
    logic [23:0] a_addr, b_addr;
    logic [7:0]  a_data, b_data;
    logic        a_ok, b_ok, a_busy, b_busy;
    logic [23:0] rom_addr;
    logic        rom_cs;
    logic [7:0]  rom_data;
    logic        rom_ok;
    logic        tout_err;

    int n_cmp = 0;
    int n_err = 0;
    int a_okn = 0;
    int b_okn = 0;
    int cs_rises = 0;
    logic cs_prev = 1'b0;
    int a0, b0, c0;

    jt10_adpcm_romarb #(.TIMEOUT(31)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_addr(a_addr), .a_data(a_data), .a_ok(a_ok), .a_busy(a_busy),
        .b_req(b_req), .b_addr(b_addr), .b_data(b_data), .b_ok(b_ok), .b_busy(b_busy),
        .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_data(rom_data), .rom_ok(rom_ok),
        .tout_err(tout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event counters sampled just after each active edge.
    always @(posedge clk) begin
        #1;
        if (a_ok === 1'b1) a_okn++;
        if (b_ok === 1'b1) b_okn++;
        if (rom_cs === 1'b1 && cs_prev !== 1'b1) cs_rises++;
        cs_prev = rom_cs;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called on the negedge where rom_cs is first seen high; returns on the
    // negedge where the requester's ok pulse must be visible (lat >= 1).
    task automatic serve(input logic [7:0] d, input int lat);
        step(lat);
        rom_ok = 1'b1;
        rom_data = d;
        step(1);
        rom_ok = 1'b0;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(1);
    endtask

    initial begin
        rst = 1'b1;
        a_req = 1'b0; b_req = 1'b0; a_addr = 24'd0; b_addr = 24'd0;
        rom_data = 8'h00; rom_ok = 1'b0;
        step(2);
        chk("rst_rom_cs", {31'd0, rom_cs}, 32'd0);
        chk("rst_rom_addr", {8'd0, rom_addr}, 32'd0);
        chk("rst_a_data", {24'd0, a_data}, 32'd0);
        chk("rst_b_data", {24'd0, b_data}, 32'd0);
        chk("rst_oks", {30'd0, a_ok, b_ok}, 32'd0);
        chk("rst_busy", {30'd0, a_busy, b_busy}, 32'd0);
        chk("rst_tout", {31'd0, tout_err}, 32'd0);
        rst = 1'b0;
        step(2);

        // Single miss at 0x000100, ROM ok 3 cycles after cs.
        a0 = a_okn; b0 = b_okn;
        a_req = 1'b1; a_addr = 24'h000100;
        step(1);
        a_req = 1'b0;
        chk("miss_busy", {31'd0, a_busy}, 32'd1);
        chk("miss_cs_early", {31'd0, rom_cs}, 32'd0);
        step(1);
        chk("miss_cs", {31'd0, rom_cs}, 32'd1);
        chk("miss_addr", {8'd0, rom_addr}, 32'h000100);
        step(2);
        chk("miss_ok_early", {31'd0, a_ok}, 32'd0);
        step(1);
        rom_ok = 1'b1; rom_data = 8'h5A;
        step(1);
        rom_ok = 1'b0;
        chk("miss_ok", {31'd0, a_ok}, 32'd1);
        chk("miss_data", {24'd0, a_data}, 32'h5A);
        chk("miss_cs_off", {31'd0, rom_cs}, 32'd0);
        step(1);
        chk("miss_ok_1cyc", {31'd0, a_ok}, 32'd0);
        chk("miss_a_oks", a_okn - a0, 32'd1);
        chk("miss_no_b_ok", b_okn - b0, 32'd0);

        // Cache hit on the same byte, then a neighbouring miss.
        c0 = cs_rises;
        a_req = 1'b1; a_addr = 24'h000100;
        step(1);
        a_req = 1'b0;
        chk("hit_ok", {31'd0, a_ok}, 32'd1);
        chk("hit_data", {24'd0, a_data}, 32'h5A);
        chk("hit_busy", {31'd0, a_busy}, 32'd0);
        step(2);
        chk("hit_no_rom", cs_rises - c0, 32'd0);
        a_req = 1'b1; a_addr = 24'h000101;
        step(1);
        a_req = 1'b0;
        chk("hit_next_ok0", {31'd0, a_ok}, 32'd0);
        step(1);
        chk("next_cs", {31'd0, rom_cs}, 32'd1);
        chk("next_addr", {8'd0, rom_addr}, 32'h000101);
        serve(8'h66, 1);
        chk("next_data", {23'd0, a_ok, a_data}, 32'h166);

        // Ties: fresh reset so last_gnt is B and A wins the first tie.
        pulse_rst();
        a_req = 1'b1; a_addr = 24'h10; b_req = 1'b1; b_addr = 24'h20;
        step(1);
        a_req = 1'b0; b_req = 1'b0;
        chk("tie_busy", {30'd0, a_busy, b_busy}, 32'd3);
        step(1);
        chk("tie1_first", {7'd0, rom_cs, rom_addr}, 32'h01000010);
        serve(8'h11, 1);
        chk("tie1_a", {22'd0, a_ok, b_ok, a_data}, 32'h211);
        chk("tie1_gap", {31'd0, rom_cs}, 32'd0);
        step(1);
        chk("tie1_second", {7'd0, rom_cs, rom_addr}, 32'h01000020);
        serve(8'h22, 2);
        chk("tie1_b", {22'd0, a_ok, b_ok, b_data}, 32'h122);
        step(1);
        a_req = 1'b1; a_addr = 24'h50; b_req = 1'b1; b_addr = 24'h60;
        step(1);
        a_req = 1'b0; b_req = 1'b0;
        step(1);
        chk("tie2_first", {7'd0, rom_cs, rom_addr}, 32'h01000050);
        serve(8'h55, 1);
        step(1);
        chk("tie2_second", {7'd0, rom_cs, rom_addr}, 32'h01000060);
        serve(8'h56, 1);
        chk("tie2_b", {23'd0, b_ok, b_data}, 32'h156);
        step(1);
        a_req = 1'b1; a_addr = 24'h70;
        step(2);
        a_req = 1'b0;
        chk("aonly_addr", {7'd0, rom_cs, rom_addr}, 32'h01000070);
        serve(8'h77, 1);
        step(1);
        a_req = 1'b1; a_addr = 24'h80; b_req = 1'b1; b_addr = 24'h90;
        step(1);
        a_req = 1'b0; b_req = 1'b0;
        step(1);
        chk("tie3_first_b", {7'd0, rom_cs, rom_addr}, 32'h01000090);
        serve(8'h99, 1);
        chk("tie3_b", {22'd0, a_ok, b_ok, b_data}, 32'h199);
        step(1);
        chk("tie3_second_a", {7'd0, rom_cs, rom_addr}, 32'h01000080);
        serve(8'h88, 1);
        chk("tie3_a", {23'd0, a_ok, a_data}, 32'h188);

        // Busy drop: the second B request arrives while B is pending.
        step(1);
        b0 = b_okn; c0 = cs_rises;
        b_req = 1'b1; b_addr = 24'h30;
        step(1);
        b_addr = 24'h40;
        chk("drop_busy", {31'd0, b_busy}, 32'd1);
        step(1);
        b_req = 1'b0;
        chk("drop_addr", {7'd0, rom_cs, rom_addr}, 32'h01000030);
        serve(8'h33, 2);
        chk("drop_b", {23'd0, b_ok, b_data}, 32'h133);
        step(6);
        chk("drop_one_fetch", cs_rises - c0, 32'd1);
        chk("drop_one_ok", b_okn - b0, 32'd1);

        // Timeout: no rom_ok at all.
        a_req = 1'b1; a_addr = 24'h000200;
        step(1);
        a_req = 1'b0;
        step(1);
        chk("to_cs", {7'd0, rom_cs, rom_addr}, 32'h01000200);
        step(31);
        chk("to_cs_held", {29'd0, rom_cs, a_ok, tout_err}, 32'd4);
        step(1);
        chk("to_cs_fall", {31'd0, rom_cs}, 32'd0);
        chk("to_ok", {23'd0, a_ok, a_data}, 32'h100);
        chk("to_err", {31'd0, tout_err}, 32'd1);
        step(2);
        a_req = 1'b1; a_addr = 24'h000200;
        step(1);
        a_req = 1'b0;
        chk("to_refetch_no_hit", {31'd0, a_ok}, 32'd0);
        step(1);
        chk("to_refetch", {7'd0, rom_cs, rom_addr}, 32'h01000200);
        serve(8'h2C, 1);
        chk("to_refetch_data", {23'd0, a_ok, a_data}, 32'h12C);
        chk("to_err_sticky", {31'd0, tout_err}, 32'd1);

        // Stale ok: rom_ok stuck high, data must come from the second WAIT cycle.
        pulse_rst();
        chk("rst_clears_tout", {31'd0, tout_err}, 32'd0);
        rom_ok = 1'b1; rom_data = 8'hD0;
        a_req = 1'b1; a_addr = 24'h000300;
        step(1);
        a_req = 1'b0;
        step(1);
        chk("stale_cs", {31'd0, rom_cs}, 32'd1);
        rom_data = 8'hE1;
        step(1);
        chk("stale_not_first", {31'd0, a_ok}, 32'd0);
        rom_data = 8'hE2;
        step(1);
        chk("stale_second", {23'd0, a_ok, a_data}, 32'h1E2);

        // Asynchronous reset in the middle of a fetch.
        step(1);
        a_req = 1'b1; a_addr = 24'h000301;
        step(1);
        a_req = 1'b0;
        step(1);
        chk("ar_cs", {31'd0, rom_cs}, 32'd1);
        a0 = a_okn;
        rst = 1'b1;
        #1;
        chk("ar_cs_async", {31'd0, rom_cs}, 32'd0);
        rom_ok = 1'b0;
        step(2);
        rst = 1'b0;
        chk("ar_no_ok", a_okn - a0, 32'd0);
        step(1);
        a_req = 1'b1; a_addr = 24'h000300;
        step(1);
        a_req = 1'b0;
        chk("ar_cache_cleared", {31'd0, a_ok}, 32'd0);
        step(1);
        chk("ar_refetch", {7'd0, rom_cs, rom_addr}, 32'h01000300);
        serve(8'hE7, 1);
        chk("ar_refetch_data", {23'd0, a_ok, a_data}, 32'h1E7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
